// File: rtl/reloj_pkg.sv
// reloj_pkg: shared widths, digit limits, load_Data field layout and the
// load FSM state type for the BCD time-of-day clock.
`timescale 1ns/1ps
package reloj_pkg;

  // Digit widths
  localparam int HR_D_W = 2;
  localparam int DIG_W  = 4;
  localparam int DEC_W  = 3;

  // Per-digit limits
  localparam int SEG_D_MAX = 5;
  localparam int MIN_D_MAX = 5;
  localparam int UNID_MAX  = 9;

  // load_Data = {hr_D[1:0], hr_U[3:0], min_D[2:0], min_U[3:0], seg_D[2:0], seg_U[3:0]}
  localparam int LOAD_W    = 20;
  localparam int SEG_U_OFS = 0;
  localparam int SEG_D_OFS = 4;
  localparam int MIN_U_OFS = 7;
  localparam int MIN_D_OFS = 11;
  localparam int HR_U_OFS  = 14;
  localparam int HR_D_OFS  = 18;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    VALIDA      = 2'd1,
    ESPERA_BAJA = 2'd2
  } carga_est_t;

  // True when every field of a packed time is a legal BCD digit and the
  // hour does not exceed hr_max.
  function automatic logic hora_bcd_valida(input logic [LOAD_W-1:0] d,
                                           input int hr_max);
    logic [HR_D_W-1:0] hr_d;
    logic [DIG_W-1:0]  hr_u;
    logic [DEC_W-1:0]  min_d;
    logic [DIG_W-1:0]  min_u;
    logic [DEC_W-1:0]  seg_d;
    logic [DIG_W-1:0]  seg_u;
    int                horas;
    hr_d  = d[HR_D_OFS  +: HR_D_W];
    hr_u  = d[HR_U_OFS  +: DIG_W];
    min_d = d[MIN_D_OFS +: DEC_W];
    min_u = d[MIN_U_OFS +: DIG_W];
    seg_d = d[SEG_D_OFS +: DEC_W];
    seg_u = d[SEG_U_OFS +: DIG_W];
    horas = int'(hr_d) * 32'sd10 + int'(hr_u);
    return (hr_u  <= DIG_W'(UNID_MAX))  &&
           (min_u <= DIG_W'(UNID_MAX))  &&
           (seg_u <= DIG_W'(UNID_MAX))  &&
           (min_d <= DEC_W'(MIN_D_MAX)) &&
           (seg_d <= DEC_W'(SEG_D_MAX)) &&
           (horas <= hr_max);
  endfunction

endpackage

// File: rtl/digito_bcd_mod.sv
// digito_bcd_mod: one modulo-(MAX+1) decimal digit with synchronous load.
// carry is high in the cycle the digit rolls MAX -> 0.
`timescale 1ns/1ps
module digito_bcd_mod #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk_Entrada,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] dig,
  output logic         carry
);

  logic [W-1:0] dig_r;
  logic         en_tope_s;

  assign en_tope_s = (dig_r == W'(MAX));
  assign carry     = inc & en_tope_s;
  assign dig       = dig_r;

  // Digit register: load wins over increment, increment wraps MAX -> 0
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      dig_r <= '0;
    end else if (load) begin
      dig_r <= load_val;
    end else if (inc) begin
      dig_r <= en_tope_s ? '0 : dig_r + W'(1);
    end else begin
      dig_r <= dig_r;
    end
  end

endmodule

// File: rtl/reloj_bcd_hms.sv
// reloj_bcd_hms: 24-hour HH:MM:SS clock in packed BCD, advanced by rising
// edges of the 1 Hz divider output, with a validated time-set handshake.
// Optional alarm comparator enabled by defining RELOJ_ALARMA_EN.
`timescale 1ns/1ps
module reloj_bcd_hms
  import reloj_pkg::*;
#(
  parameter int TICKS_POR_SEG = 1,
  parameter int HR_MAX        = 23
) (
  input  logic              clk_Entrada,
  input  logic              rst,
  input  logic              tick_In,
  input  logic              en,
  input  logic              load_Req,
  input  logic [LOAD_W-1:0] load_Data,
  output logic              load_Ack,
  output logic              load_Err,
  output logic [HR_D_W-1:0] hr_D,
  output logic [DIG_W-1:0]  hr_U,
  output logic [DEC_W-1:0]  min_D,
  output logic [DIG_W-1:0]  min_U,
  output logic [DEC_W-1:0]  seg_D,
  output logic [DIG_W-1:0]  seg_U,
  output logic              seg_Pulso,
`ifdef RELOJ_ALARMA_EN
  input  logic              alarma_Set,
  input  logic [LOAD_W-1:0] alarma_Data,
  output logic              alarma_Pulso,
`endif
  output logic              dia_Pulso
);

  // Edge detect and prescaler
  logic       tick_q_r;
  logic [7:0] presc_r;
  logic       flanco_s;
  logic       cuenta_s;
  logic       fin_presc_s;
  logic       avance_s;

  // Load handshake
  carga_est_t        est_r;
  carga_est_t        est_nxt_s;
  logic [LOAD_W-1:0] dato_r;
  logic              valida_s;
  logic              carga_wr_s;
  logic              ack_s;
  logic              err_s;

  // Registered pulses
  logic load_ack_r;
  logic load_err_r;
  logic seg_pulso_r;
  logic dia_pulso_r;

  // Digit chain
  logic [HR_D_W-1:0] hr_d_s;
  logic [DIG_W-1:0]  hr_u_s;
  logic [DEC_W-1:0]  min_d_s;
  logic [DIG_W-1:0]  min_u_s;
  logic [DEC_W-1:0]  seg_d_s;
  logic [DIG_W-1:0]  seg_u_s;
  logic c_su_s, c_sd_s, c_mu_s, c_md_s, c_hu_s, c_hd_s;
  logic hora_tope_s;
  logic vuelta_hr_s;
  logic carga_hr_s;

  assign flanco_s    = tick_In & ~tick_q_r;
  assign cuenta_s    = flanco_s & en;
  assign fin_presc_s = (presc_r == 8'(TICKS_POR_SEG - 1));
  // A valid load in the same cycle swallows the advance.
  assign avance_s    = cuenta_s & fin_presc_s & ~carga_wr_s;
  assign valida_s    = hora_bcd_valida(dato_r, HR_MAX);

  // Tick edge register: always tracks tick_In so en=0 never creates a late edge
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      tick_q_r <= 1'b0;
    end else begin
      tick_q_r <= tick_In;
    end
  end

  // Prescaler: counts enabled edges, cleared by a valid load
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      presc_r <= 8'd0;
    end else if (carga_wr_s) begin
      presc_r <= 8'd0;
    end else if (cuenta_s) begin
      presc_r <= fin_presc_s ? 8'd0 : presc_r + 8'd1;
    end else begin
      presc_r <= presc_r;
    end
  end

  // Load FSM state register
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      est_r <= IDLE;
    end else begin
      est_r <= est_nxt_s;
    end
  end

  // Load FSM next state: a held request is consumed once, then must drop
  always_comb begin
    est_nxt_s = est_r;
    case (est_r)
      IDLE: begin
        if (load_Req) begin
          est_nxt_s = VALIDA;
        end else begin
          est_nxt_s = IDLE;
        end
      end
      VALIDA: begin
        est_nxt_s = ESPERA_BAJA;
      end
      ESPERA_BAJA: begin
        if (!load_Req) begin
          est_nxt_s = IDLE;
        end else begin
          est_nxt_s = ESPERA_BAJA;
        end
      end
      default: begin
        est_nxt_s = IDLE;
      end
    endcase
  end

  // Load FSM outputs: the validation verdict is taken in VALIDA only
  always_comb begin
    carga_wr_s = 1'b0;
    ack_s      = 1'b0;
    err_s      = 1'b0;
    case (est_r)
      VALIDA: begin
        if (valida_s) begin
          carga_wr_s = 1'b1;
          ack_s      = 1'b1;
        end else begin
          err_s      = 1'b1;
        end
      end
      default: begin
        carga_wr_s = 1'b0;
        ack_s      = 1'b0;
        err_s      = 1'b0;
      end
    endcase
  end

  // Capture load_Data when a request is accepted in IDLE
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      dato_r <= '0;
    end else if ((est_r == IDLE) && load_Req) begin
      dato_r <= load_Data;
    end else begin
      dato_r <= dato_r;
    end
  end

  // Output pulses, registered so they line up with the new digits
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      load_ack_r  <= 1'b0;
      load_err_r  <= 1'b0;
      seg_pulso_r <= 1'b0;
      dia_pulso_r <= 1'b0;
    end else begin
      load_ack_r  <= ack_s;
      load_err_r  <= err_s;
      seg_pulso_r <= avance_s;
      dia_pulso_r <= vuelta_hr_s;
    end
  end

  // Hours wrap at HR_MAX; a tens overflow is treated the same way.
  assign hora_tope_s = (hr_d_s == HR_D_W'(HR_MAX / 10)) &&
                       (hr_u_s == DIG_W'(HR_MAX % 10));
  assign vuelta_hr_s = c_md_s & hora_tope_s;
  assign carga_hr_s  = carga_wr_s | vuelta_hr_s | c_hd_s;

  digito_bcd_mod #(.W(DIG_W), .MAX(UNID_MAX)) u_seg_u (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (avance_s),
    .load     (carga_wr_s),
    .load_val (dato_r[SEG_U_OFS +: DIG_W]),
    .dig      (seg_u_s),
    .carry    (c_su_s)
  );

  digito_bcd_mod #(.W(DEC_W), .MAX(SEG_D_MAX)) u_seg_d (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (c_su_s),
    .load     (carga_wr_s),
    .load_val (dato_r[SEG_D_OFS +: DEC_W]),
    .dig      (seg_d_s),
    .carry    (c_sd_s)
  );

  digito_bcd_mod #(.W(DIG_W), .MAX(UNID_MAX)) u_min_u (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (c_sd_s),
    .load     (carga_wr_s),
    .load_val (dato_r[MIN_U_OFS +: DIG_W]),
    .dig      (min_u_s),
    .carry    (c_mu_s)
  );

  digito_bcd_mod #(.W(DEC_W), .MAX(MIN_D_MAX)) u_min_d (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (c_mu_s),
    .load     (carga_wr_s),
    .load_val (dato_r[MIN_D_OFS +: DEC_W]),
    .dig      (min_d_s),
    .carry    (c_md_s)
  );

  digito_bcd_mod #(.W(DIG_W), .MAX(UNID_MAX)) u_hr_u (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (c_md_s & ~vuelta_hr_s),
    .load     (carga_hr_s),
    .load_val (carga_wr_s ? dato_r[HR_U_OFS +: DIG_W] : DIG_W'(0)),
    .dig      (hr_u_s),
    .carry    (c_hu_s)
  );

  digito_bcd_mod #(.W(HR_D_W), .MAX(2)) u_hr_d (
    .clk_Entrada (clk_Entrada), .rst (rst),
    .inc      (c_hu_s),
    .load     (carga_hr_s),
    .load_val (carga_wr_s ? dato_r[HR_D_OFS +: HR_D_W] : HR_D_W'(0)),
    .dig      (hr_d_s),
    .carry    (c_hd_s)
  );

  assign hr_D      = hr_d_s;
  assign hr_U      = hr_u_s;
  assign min_D     = min_d_s;
  assign min_U     = min_u_s;
  assign seg_D     = seg_d_s;
  assign seg_U     = seg_u_s;
  assign load_Ack  = load_ack_r;
  assign load_Err  = load_err_r;
  assign seg_Pulso = seg_pulso_r;
  assign dia_Pulso = dia_pulso_r;

`ifdef RELOJ_ALARMA_EN
  logic [LOAD_W-1:0] alarma_r;
  logic [LOAD_W-1:0] hora_act_s;
  logic              alarma_ok_s;

  // Alarm register: all-ones at reset is out of range, so it never fires
  always_ff @(posedge clk_Entrada or posedge rst) begin
    if (rst) begin
      alarma_r <= '1;
    end else if (alarma_Set) begin
      alarma_r <= alarma_Data;
    end else begin
      alarma_r <= alarma_r;
    end
  end

  assign hora_act_s   = {hr_d_s, hr_u_s, min_d_s, min_u_s, seg_d_s, seg_u_s};
  assign alarma_ok_s  = hora_bcd_valida(alarma_r, HR_MAX);
  assign alarma_Pulso = seg_pulso_r & alarma_ok_s & (hora_act_s == alarma_r);
`endif

endmodule

// File: tb/tb_reloj_bcd_hms.sv
// Scoreboard bench for reloj_bcd_hms: a seconds-of-day model predicts every
// ack/err/second/day event; a monitor pops and compares on each DUT pulse.
`timescale 1ns/1ps
module tb_reloj_bcd_hms;

  localparam int TPS = 4;

  logic        clk_Entrada = 1'b0;
  logic        rst;
  logic        tick_In;
  logic        en;
  logic        load_Req;
  logic [19:0] load_Data;
  logic        load_Ack, load_Err, seg_Pulso, dia_Pulso;
  logic [1:0]  hr_D;
  logic [3:0]  hr_U, min_U, seg_U;
  logic [2:0]  min_D, seg_D;
  logic [19:0] dut_tm;

  typedef struct {
    bit          ack;
    bit          err;
    bit          seg;
    bit          dia;
    logic [19:0] tm;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev_m;
  int  n_chk  = 0;
  int  n_fail = 0;
  int  t_mod  = 0;   // seconds of day
  int  p_mod  = 0;   // enabled edges since last second

  always #5 clk_Entrada = ~clk_Entrada;

  reloj_bcd_hms #(.TICKS_POR_SEG(TPS), .HR_MAX(23)) dut (
    .clk_Entrada (clk_Entrada), .rst (rst), .tick_In (tick_In), .en (en),
    .load_Req (load_Req), .load_Data (load_Data),
    .load_Ack (load_Ack), .load_Err (load_Err),
    .hr_D (hr_D), .hr_U (hr_U), .min_D (min_D), .min_U (min_U),
    .seg_D (seg_D), .seg_U (seg_U),
    .seg_Pulso (seg_Pulso), .dia_Pulso (dia_Pulso)
  );

  assign dut_tm = {hr_D, hr_U, min_D, min_U, seg_D, seg_U};

  function automatic logic [19:0] empaca(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit decodifica(input logic [19:0] d, output int t);
    int hd, hu, md, mu, sd, su;
    hd = int'(d[19:18]); hu = int'(d[17:14]); md = int'(d[13:11]);
    mu = int'(d[10:7]);  sd = int'(d[6:4]);   su = int'(d[3:0]);
    t = (hd * 10 + hu) * 3600 + (md * 10 + mu) * 60 + sd * 10 + su;
    return (hu <= 9) && (mu <= 9) && (su <= 9) && (sd <= 5) && (md <= 5) &&
           (hd * 10 + hu <= 23);
  endfunction

  task automatic chk(input string nombre, input logic [19:0] got, input logic [19:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %05h, required %05h", nombre, got, req);
    end
  endtask

  task automatic avanza_modelo(output bit s, output bit d);
    s = 1'b0; d = 1'b0;
    p_mod++;
    if (p_mod == TPS) begin
      p_mod = 0;
      t_mod = (t_mod + 1) % 86400;
      s = 1'b1;
      d = (t_mod == 0);
    end
  endtask

  task automatic pulso_tick(input bit en_v);
    bit  s, d;
    ev_t e;
    en = en_v;
    tick_In = 1'b1;
    if (en_v) begin
      avanza_modelo(s, d);
      if (s) begin
        e.ack = 1'b0; e.err = 1'b0; e.seg = 1'b1; e.dia = d; e.tm = empaca(t_mod);
        exp_q.push_back(e);
      end
    end
    repeat ($urandom_range(1, 3)) begin @(posedge clk_Entrada); #1; end
    tick_In = 1'b0;
    repeat ($urandom_range(1, 3)) begin @(posedge clk_Entrada); #1; end
  endtask

  // con_tick puts a tick edge on the very cycle the load is written.
  task automatic carga(input logic [19:0] d, input bit con_tick, input int extra);
    int  tv;
    bit  ok, s, dd;
    ev_t e;
    load_Req = 1'b1;
    load_Data = d;
    @(posedge clk_Entrada); #1;
    load_Data = 20'($urandom);
    ok = decodifica(d, tv);
    e.ack = ok; e.err = !ok; e.seg = 1'b0; e.dia = 1'b0;
    if (con_tick) begin
      tick_In = 1'b1;
      if (!ok && en) begin
        avanza_modelo(s, dd);
        e.seg = s; e.dia = dd;
      end
    end
    if (ok) begin
      t_mod = tv;
      p_mod = 0;
    end
    e.tm = empaca(t_mod);
    exp_q.push_back(e);
    @(posedge clk_Entrada); #1;
    tick_In = 1'b0;
    repeat (extra) begin @(posedge clk_Entrada); #1; end
    load_Req = 1'b0;
    repeat (2) begin @(posedge clk_Entrada); #1; end
  endtask

  // Monitor: every pulse from the DUT must match the next predicted event.
  always @(negedge clk_Entrada) begin
    if (!rst && (load_Ack || load_Err || seg_Pulso || dia_Pulso)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL evento_inesperado: got ack=%0b err=%0b seg=%0b dia=%0b tm=%05h, required no event",
                 load_Ack, load_Err, seg_Pulso, dia_Pulso, dut_tm);
      end else begin
        ev_m = exp_q.pop_front();
        if (load_Ack !== ev_m.ack || load_Err !== ev_m.err || seg_Pulso !== ev_m.seg ||
            dia_Pulso !== ev_m.dia || dut_tm !== ev_m.tm) begin
          n_fail++;
          $display("FAIL evento: got ack=%0b err=%0b seg=%0b dia=%0b tm=%05h, required ack=%0b err=%0b seg=%0b dia=%0b tm=%05h",
                   load_Ack, load_Err, seg_Pulso, dia_Pulso, dut_tm,
                   ev_m.ack, ev_m.err, ev_m.seg, ev_m.dia, ev_m.tm);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] d;
    rst = 1'b1; tick_In = 1'b0; en = 1'b1; load_Req = 1'b0; load_Data = 20'd0;
    repeat (3) begin @(posedge clk_Entrada); #1; end
    chk("reset_digitos", dut_tm, 20'd0);
    chk("reset_pulsos", {16'd0, load_Ack, load_Err, seg_Pulso, dia_Pulso}, 20'd0);
    rst = 1'b0;
    @(posedge clk_Entrada); #1;

    // Reset while the FSM sits in VALIDA
    carga(empaca(3723), 1'b0, 0);
    chk("carga_01_02_03", dut_tm, empaca(3723));
    load_Req = 1'b1; load_Data = empaca(50000);
    @(posedge clk_Entrada); #1;
    rst = 1'b1;
    @(negedge clk_Entrada);
    chk("rst_valida_digitos", dut_tm, 20'd0);
    chk("rst_valida_pulsos", {16'd0, load_Ack, load_Err, seg_Pulso, dia_Pulso}, 20'd0);
    load_Req = 1'b0;
    @(posedge clk_Entrada); #1;
    rst = 1'b0;
    t_mod = 0; p_mod = 0;
    repeat (3) begin @(posedge clk_Entrada); #1; end
    chk("rst_valida_sin_carga", dut_tm, 20'd0);

    // 00:00:58 -> 59 -> 01:00
    carga(20'h00058, 1'b0, 0);
    repeat (TPS) pulso_tick(1'b1);
    chk("hora_00_00_59", dut_tm, empaca(59));
    repeat (TPS) pulso_tick(1'b1);
    chk("hora_00_01_00", dut_tm, empaca(60));

    // Midnight wrap
    carga(empaca(86399), 1'b0, 0);
    repeat (TPS) pulso_tick(1'b1);
    chk("vuelta_dia", dut_tm, 20'd0);

    // Invalid loads, one held for ten cycles
    d = {2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0};
    carga(d, 1'b0, 8);
    d = {2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'hA};
    carga(d, 1'b0, 3);
    chk("err_sin_cambio", dut_tm, empaca(t_mod));

    // en=0 ignores edges, then four edges make one second
    carga(empaca(100), 1'b0, 0);
    repeat (3) pulso_tick(1'b0);
    chk("en0_mantiene", dut_tm, empaca(100));
    repeat (TPS - 1) pulso_tick(1'b1);
    chk("presc_sin_avance", dut_tm, empaca(100));
    pulso_tick(1'b1);
    chk("presc_avance", dut_tm, empaca(101));

    // Valid load on an advancing edge: load wins, prescaler restarts
    carga(empaca(200), 1'b0, 0);
    repeat (TPS - 1) pulso_tick(1'b1);
    carga(empaca(4000), 1'b1, 0);
    chk("coincide_carga", dut_tm, empaca(4000));
    repeat (TPS - 1) pulso_tick(1'b1);
    chk("coincide_presc0", dut_tm, empaca(4000));
    pulso_tick(1'b1);
    chk("coincide_avance", dut_tm, empaca(4001));

    // Randomised mix
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pulso_tick($urandom_range(0, 3) != 0);
        3:       carga(empaca($urandom_range(0, 86399)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4));
        4:       carga(20'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        default: carga(empaca(86400 - $urandom_range(1, 3)), 1'b0, 0);
      endcase
    end
    repeat (5) begin @(posedge clk_Entrada); #1; end
    chk("final_digitos", dut_tm, empaca(t_mod));

    while (exp_q.size() > 0) begin
      ev_m = exp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL evento_faltante: got no event, required ack=%0b err=%0b seg=%0b dia=%0b tm=%05h",
               ev_m.ack, ev_m.err, ev_m.seg, ev_m.dia, ev_m.tm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reloj_bcd_hms.md
Name: reloj_bcd_hms

Overview:
Downstream consumer of the 50 MHz → 1 Hz frequency divider. Takes the divider's 1 Hz square wave, detects its rising edge, and keeps a 24-hour HH:MM:SS time of day in packed BCD. The BCD digits feed the display/multiplexer stage. Supports a validated load (time-set) handshake and a run enable.

Parameters:
- TICKS_POR_SEG, default 1: tick_In rising edges per one-second advance. Allowed range 1..255. Simulation benches may use 1 with a fast divider.
- HR_MAX, default 23: last valid hour before wrap to 00. Fixed range 0..23.

Ports:
- clk_Entrada  in  1  system clock, 50 MHz. Same clock as the divider.
- rst  in  1  reset, asynchronous, active-high.
- tick_In  in  1  divider output, 1 Hz square wave, synchronous to clk_Entrada.
- en  in  1  run enable. When low, ticks are ignored.
- load_Req  in  1  time-set request. Level signal; held until ack or error.
- load_Data  in  20  {hr_D[1:0], hr_U[3:0], min_D[2:0], min_U[3:0], seg_D[2:0], seg_U[3:0]}.
- load_Ack  out  1  one-cycle pulse: load accepted.
- load_Err  out  1  one-cycle pulse: load rejected as invalid BCD/range.
- hr_D  out  2  hours tens.
- hr_U  out  4  hours units.
- min_D  out  3  minutes tens.
- min_U  out  4  minutes units.
- seg_D  out  3  seconds tens.
- seg_U  out  4  seconds units.
- seg_Pulso  out  1  one-cycle pulse on every seconds advance.
- dia_Pulso  out  1  one-cycle pulse on wrap HR_MAX:59:59 → 00:00:00.

Behaviour:
- Reset (asynchronous, any time including mid-load): all time digits = 0; load_Ack, load_Err, seg_Pulso, dia_Pulso = 0; tick edge register = 0; prescaler = 0; FSM = IDLE.
- Edge detect:
  - tick_q is registered from tick_In.
  - Edge is true when tick_In=1 and tick_q=0 at a clock edge.
  - Exactly one edge per low→high transition of tick_In, regardless of high duration.
- Prescaler, 8 bits:
  - Increments on each edge while en=1.
  - When it equals TICKS_POR_SEG-1 on an edge, it clears and the time advances at that same clock edge.
  - seg_Pulso = 1 for that one cycle (registered, coincident with the new digits).
- en=0: edges are still tracked in tick_q but are discarded. Prescaler and digits hold.
- Advance chain:
  - seg_U 9→0 carries into seg_D.
  - seg_D 5→0 carries into min_U.
  - min_U 9→0 carries into min_D.
  - min_D 5→0 carries into hours.
  - Hours: units 9→0 with tens +1. At hour == HR_MAX (2,3 by default) the hours wrap to 0,0.
  - Full wrap HR_MAX:59:59 → 00:00:00 asserts dia_Pulso together with seg_Pulso.
- Load FSM, states IDLE, VALIDA, ESPERA_BAJA:
  - IDLE: load_Req=1 → VALIDA, capturing load_Data.
  - VALIDA (one cycle): check all unit digits ≤9, seg_D ≤5, min_D ≤5, and hours (hr_D*10+hr_U) ≤ HR_MAX.
    - Valid: write digits, clear prescaler, pulse load_Ack.
    - Invalid: digits unchanged, pulse load_Err.
    - Both outcomes → ESPERA_BAJA.
  - ESPERA_BAJA: wait for load_Req=0 → IDLE. A held request never reloads.
  - Latency: request seen at cycle N; ack/err and new digits visible at N+2.
- Simultaneous events:
  - A second advance in the same cycle as a valid load write is discarded. The load wins and seg_Pulso stays 0.
  - Edges in IDLE/ESPERA_BAJA advance normally.
  - An advance during VALIDA with an invalid load proceeds normally.
- Arithmetic: each digit is a separate modulo counter, no binary-to-BCD conversion. Overflow of the prescaler is impossible by parameter range.

Optional Feature:
- Macro: RELOJ_ALARMA_EN.
- Defined:
  - Adds inputs alarma_Set (1) and alarma_Data (20, same packing as load_Data).
  - Adds output alarma_Pulso (1).
  - alarma_Set=1 stores alarma_Data, unvalidated, into an internal register. Reset value of the register is all-ones, which never matches.
  - alarma_Pulso pulses for one cycle when seg_Pulso=1 and the new time equals the stored alarm. Disabled if the stored value is out of range.
- Undefined: the ports and logic are absent; the interface is exactly as listed above.

Decomposition:
- Shared package reloj_pkg:
  - Digit widths: HR_D_W=2, DIG_W=4, DEC_W=3.
  - Limits: SEG_D_MAX=5, MIN_D_MAX=5, UNID_MAX=9.
  - LOAD_W=20 and the load_Data field offsets.
  - Load FSM state typedef: IDLE, VALIDA, ESPERA_BAJA.
- Sub-module: digito_bcd_mod, a parameterised modulo-N digit counter with inc, load, load value, digit out, and carry out. Instantiate six times; the hours wrap is handled in the top.

Test Plan:
- Reset → all digits 0, all pulses 0. Assert rst mid-VALIDA → same, FSM returns to IDLE.
- Load 00:00:58 (0x00058), then 2 tick edges → 00:00:59, then 00:01:00. seg_Pulso pulses twice, dia_Pulso stays 0.
- Load 23:59:59, then 1 edge → 00:00:00 with seg_Pulso=dia_Pulso=1 for one cycle.
- Load 24:00:00 or seg_U=0xA → load_Err pulse, digits unchanged. Holding load_Req high for 10 cycles gives only one err.
- en=0 with 3 edges → digits unchanged. en=1 with TICKS_POR_SEG=4 → advance only on the 4th edge.
- Valid load coincident with an advancing edge → loaded value shown, no seg_Pulso, prescaler = 0.
